// File: rtl/ym_phase_gen.sv
// Two-phase c1/c2 clock-enable generator with slot counter, cycle-sync flag
// and a post-reset stretched internal clear.
module ym_phase_gen #(
  parameter int DIV       = 6,
  parameter int SLOTS     = 24,
  parameter int SLOT_W    = 5,
  parameter int IC_CYCLES = 2
) (
  input  logic              MCLK,
  input  logic              reset,
  input  logic              hold,
  output logic              c1,
  output logic              c2,
  output logic [SLOT_W-1:0] slot,
  output logic              sync,
  output logic              ic_out
);

  localparam int PRE_W = $clog2(2 * DIV);
  localparam int IC_W  = (IC_CYCLES > 1) ? $clog2(IC_CYCLES) : 1;

  localparam logic [PRE_W-1:0]  PRE_C1    = PRE_W'(DIV - 1);
  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(2 * DIV - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOTS - 1);
  localparam logic [IC_W-1:0]   ICC_LAST  = IC_W'(IC_CYCLES - 1);

  logic [PRE_W-1:0]  r_pre;
  logic              r_c1;
  logic              r_c2;
  logic [SLOT_W-1:0] r_slot;
  logic [IC_W-1:0]   r_icc;
  logic              r_ic;

  logic w_last_slot;
  logic w_wrap;

  assign w_last_slot = (r_slot == SLOT_LAST);
  assign w_wrap      = r_c2 && w_last_slot;

  // NOTE: every state register uses non-blocking assignment so all of them
  // see the pre-edge values of r_pre / r_c2 / r_slot in the same cycle.
  always_ff @(posedge MCLK) begin
    if (reset) begin
      r_pre  <= '0;
      r_c1   <= 1'b0;
      r_c2   <= 1'b0;
      r_slot <= '0;
      r_icc  <= '0;
      r_ic   <= 1'b1;
    end else if (hold) begin
      // Everything but the pulses freezes, so resumption continues from r_pre.
      r_c1 <= 1'b0;
      r_c2 <= 1'b0;
    end else begin
      r_pre <= (r_pre == PRE_LAST) ? '0 : r_pre + PRE_W'(1);
      r_c1  <= (r_pre == PRE_C1);
      r_c2  <= (r_pre == PRE_LAST);
      if (r_c2) begin
        r_slot <= w_last_slot ? '0 : r_slot + SLOT_W'(1);
      end
      if (w_wrap && r_ic) begin
        if (r_icc == ICC_LAST) begin
          r_ic <= 1'b0;
        end else begin
          r_icc <= r_icc + IC_W'(1);
        end
      end
    end
  end

  assign c1     = r_c1;
  assign c2     = r_c2;
  assign slot   = r_slot;
  assign sync   = w_last_slot;
  assign ic_out = r_ic;

endmodule

// File: tb/tb_ym_phase_gen.sv
// Self-checking bench for ym_phase_gen: a DIV=6/SLOTS=24 instance and a
// DIV=1/SLOTS=2 instance driven together and compared against an edge-count model.
module tb_ym_phase_gen;

  logic       MCLK = 1'b0;
  logic       reset;
  logic       hold;

  logic       c1_a, c2_a, sync_a, ic_a;
  logic [4:0] slot_a;
  logic       c1_b, c2_b, sync_b, ic_b;
  logic [0:0] slot_b;

  ym_phase_gen #(.DIV(6), .SLOTS(24), .SLOT_W(5), .IC_CYCLES(2)) u_dut_a (
    .MCLK(MCLK), .reset(reset), .hold(hold),
    .c1(c1_a), .c2(c2_a), .slot(slot_a), .sync(sync_a), .ic_out(ic_a)
  );

  ym_phase_gen #(.DIV(1), .SLOTS(2), .SLOT_W(1), .IC_CYCLES(1)) u_dut_b (
    .MCLK(MCLK), .reset(reset), .hold(hold),
    .c1(c1_b), .c2(c2_b), .slot(slot_b), .sync(sync_b), .ic_out(ic_b)
  );

  always #5 MCLK = ~MCLK;

  int vectors     = 0;
  int miscompares = 0;

  // Model: n = unheld edges since reset (prescaler phase), cons = c2 pulses
  // that advanced the slot. Everything else is arithmetic on those two.
  int p_div   [2] = '{6, 1};
  int p_slots [2] = '{24, 2};
  int p_ic    [2] = '{2, 1};
  int n       [2];
  int cons    [2];
  bit mc1     [2];
  bit mc2     [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int slot_e [2];
    for (int k = 0; k < 2; k++) slot_e[k] = cons[k] % p_slots[k];
    check("a_c1",   32'(c1_a),   32'(mc1[0]));
    check("a_c2",   32'(c2_a),   32'(mc2[0]));
    check("a_slot", 32'(slot_a), slot_e[0]);
    check("a_sync", 32'(sync_a), 32'(slot_e[0] == p_slots[0] - 1));
    check("a_ic",   32'(ic_a),   32'(cons[0] < p_ic[0] * p_slots[0]));
    check("b_c1",   32'(c1_b),   32'(mc1[1]));
    check("b_c2",   32'(c2_b),   32'(mc2[1]));
    check("b_slot", 32'(slot_b), slot_e[1]);
    check("b_sync", 32'(sync_b), 32'(slot_e[1] == p_slots[1] - 1));
    check("b_ic",   32'(ic_b),   32'(cons[1] < p_ic[1] * p_slots[1]));
    check("a_no_overlap", 32'(c1_a & c2_a), 32'(0));
  endtask

  task automatic step(input bit rst, input bit hld);
    @(negedge MCLK);
    reset = rst;
    hold  = hld;
    @(posedge MCLK);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        n[k] = 0; cons[k] = 0; mc1[k] = 1'b0; mc2[k] = 1'b0;
      end else if (hld) begin
        mc1[k] = 1'b0; mc2[k] = 1'b0;
      end else begin
        if (mc2[k]) cons[k]++;
        n[k]++;
        mc1[k] = (n[k] % (2 * p_div[k])) == (p_div[k] % (2 * p_div[k]));
        mc2[k] = (n[k] % (2 * p_div[k])) == 0;
      end
    end
    #1;
    check_all();
  endtask

  initial begin
    bit found;
    int r;
    int len;

    reset = 1'b1;
    hold  = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n[k] = 0; cons[k] = 0; mc1[k] = 1'b0; mc2[k] = 1'b0;
    end

    // Reset, including reset while hold is high.
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);

    // Free run past two full DIV=6 slot cycles so the ic_out fall is covered.
    for (int i = 0; i < 700; i++) step(1'b0, 1'b0);

    // Hold for 10 edges with the prescaler at 3, then resume.
    for (int i = 0; i < 12 && (n[0] % 12) != 3; i++) step(1'b0, 1'b0);
    check("hold_pre_align", 32'(n[0] % 12), 32'(3));
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1);
    for (int i = 0; i < 30; i++) step(1'b0, 1'b0);

    // Reset during a c1 pulse at slot 17, then restart.
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      step(1'b0, 1'b0);
      if (mc1[0] && (cons[0] % 24) == 17) found = 1'b1;
    end
    check("midop_found", 32'(found), 32'(1));
    step(1'b1, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b0, 1'b0);

    // Randomised hold bursts and occasional resets.
    for (int i = 0; i < 2000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        step(1'b1, r[0]);
      end else if (r < 12) begin
        len = $urandom_range(1, 15);
        for (int j = 0; j < len; j++) step(1'b0, 1'b1);
      end else begin
        step(1'b0, 1'b0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
